// File: rtl/cypher_pkg.sv
// Shared definitions for the cypher link: symbol/sum widths and the
// transmitter FSM state encoding.
package cypher_pkg;

    localparam int NIBBLE_W = 4;
    localparam int SUM_W    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/cypher_phase_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero,
// marking the last cycle of the current phase.
module cypher_phase_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/cypher_transmitter.sv
// Serialises a frame of 4-bit symbols, MSB nibble first, onto the
// nibble/read-strobe link, with a running modulo-256 sum of sent nibbles.
module cypher_transmitter
    import cypher_pkg::*;
#(
    parameter int NIBBLES       = 8,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 3
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [NIBBLE_W*NIBBLES-1:0]     frame,
    output logic [NIBBLE_W-1:0]             nibble_out,
    output logic                            read,
    output logic [$clog2(NIBBLES+1)-1:0]    index,
    output logic [SUM_W-1:0]                sum,
    output logic                            busy,
    output logic                            done
);

    localparam int IW     = $clog2(NIBBLES + 1);
    localparam int FW     = NIBBLE_W * NIBBLES;
    localparam int MAX_PH = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int TW     = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

    state_t                r_state;
    state_t                w_state_next;
    logic [FW-1:0]         r_shift;
    logic [FW-1:0]         w_shift_next;
    logic [NIBBLE_W-1:0]   r_nibble;
    logic [IW-1:0]         r_index;
    logic [SUM_W-1:0]      r_sum;
    logic                  r_read;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_tc;
    logic                  w_accept;
    logic                  w_last_strobe;
    logic                  w_last_nibble;
    logic                  w_load;
    logic [TW-1:0]         w_load_val;

    always_comb begin
        w_state_next  = r_state;
        w_accept      = start && ((r_state == IDLE) || (r_state == DONE));
        w_last_strobe = (r_state == STROBE) && w_tc;
        w_last_nibble = (r_index == IW'(NIBBLES - 1));
        case (r_state)
            IDLE:    if (start) w_state_next = SETUP;
            SETUP:   if (w_tc)  w_state_next = STROBE;
            STROBE:  if (w_tc)  w_state_next = w_last_nibble ? DONE : SETUP;
            DONE:    w_state_next = start ? SETUP : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Every transition lands in a different state, so a state change is a phase entry.
    assign w_load       = (w_state_next != r_state);
    assign w_load_val   = (w_state_next == SETUP) ? TW'(SETUP_CYCLES - 1) : TW'(STROBE_CYCLES - 1);
    assign w_shift_next = r_shift << NIBBLE_W;

    cypher_phase_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift  <= '0;
            r_nibble <= '0;
            r_index  <= '0;
            r_sum    <= '0;
            r_read   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift  <= frame;
                r_nibble <= frame[FW-1 -: NIBBLE_W];
                r_index  <= '0;
                r_sum    <= '0;
            end else if (w_last_strobe) begin
                r_sum   <= r_sum + SUM_W'(r_nibble);
                r_index <= r_index + IW'(1);
                if (!w_last_nibble) begin
                    r_shift  <= w_shift_next;
                    r_nibble <= w_shift_next[FW-1 -: NIBBLE_W];
                end
            end
            // Outputs track the state being entered so they are valid in that state's first cycle.
            r_read <= (w_state_next == STROBE);
            r_busy <= (w_state_next == SETUP) || (w_state_next == STROBE);
            r_done <= (w_state_next == DONE);
        end
    end

    assign nibble_out = r_nibble;
    assign read       = r_read;
    assign index      = r_index;
    assign sum        = r_sum;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_cypher_transmitter.sv
// Directed bench for cypher_transmitter: default timing, 20-nibble wrap
// case and a SETUP=2/STROBE=1 variant.
module tb_cypher_transmitter;

    logic        clk;
    logic        reset_n;

    logic        start_a, start_b, start_c;
    logic [31:0] frame_a, frame_c;
    logic [79:0] frame_b;

    logic [3:0]  nib_a, nib_b, nib_c;
    logic        read_a, read_b, read_c;
    logic [3:0]  idx_a, idx_c;
    logic [4:0]  idx_b;
    logic [7:0]  sum_a, sum_b, sum_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    int n_vec = 0;
    int n_err = 0;

    cypher_transmitter dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .frame(frame_a),
        .nibble_out(nib_a), .read(read_a), .index(idx_a), .sum(sum_a),
        .busy(busy_a), .done(done_a)
    );

    cypher_transmitter #(.NIBBLES(20)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .frame(frame_b),
        .nibble_out(nib_b), .read(read_b), .index(idx_b), .sum(sum_b),
        .busy(busy_b), .done(done_b)
    );

    cypher_transmitter #(.SETUP_CYCLES(2), .STROBE_CYCLES(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .start(start_c), .frame(frame_c),
        .nibble_out(nib_c), .read(read_c), .index(idx_c), .sum(sum_c),
        .busy(busy_c), .done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    function automatic logic [31:0] pack_a();
        return {13'd0, nib_a, read_a, idx_a, sum_a, busy_a, done_a};
    endfunction

    function automatic logic [3:0] nib_of(input logic [31:0] fr, input int k);
        logic [31:0] t;
        t = fr >> (4 * (7 - k));
        return t[3:0];
    endfunction

    // Full cycle-by-cycle check of one default-timing frame on dut_a.
    task automatic frame_a_run(input string name, input logic [31:0] fr, input int glitch_cyc,
                               input logic [31:0] glitch_fr, input bit hold, input logic [7:0] exp_total);
        int          k, ph;
        logic [7:0]  s;
        logic [31:0] exp;
        @(negedge clk);
        frame_a = fr;
        start_a = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            k = (c - 1) / 4;
            ph = (c - 1) % 4;
            s = 8'd0;
            for (int j = 0; j < k && j < 8; j++) s = s + 8'(nib_of(fr, j));
            if (c <= 32)
                exp = {13'd0, nib_of(fr, k), (ph != 0), 4'(k), s, 1'b1, 1'b0};
            else
                exp = {13'd0, nib_of(fr, 7), 1'b0, 4'd8, s, 1'b0, 1'b1};
            chk($sformatf("%s_c%0d", name, c), pack_a(), exp);
            start_a = hold || (c == glitch_cyc - 1);
            if (c == glitch_cyc - 1) frame_a = glitch_fr;
        end
        chk($sformatf("%s_total", name), {24'd0, sum_a}, {24'd0, exp_total});
    endtask

    initial begin
        int          c;
        int          reads, run, max_run;
        logic        seen, active;

        reset_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        frame_a = 32'h0; frame_b = 80'h0; frame_c = 32'h0;
        #2;
        chk("reset_state", pack_a(), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", pack_a(), 32'h0);

        frame_a_run("f0", 32'h0130_1062, 0, 32'h0, 1'b0, 8'h0D);
        frame_a_run("ff", 32'hFFFF_FFFF, 0, 32'h0, 1'b0, 8'h78);
        frame_a_run("ign", 32'h0130_1062, 10, 32'hFFFF_FFFF, 1'b0, 8'h0D);

        // Back-to-back: start held through DONE.
        frame_a_run("b2b", 32'h0130_1062, 0, 32'h0, 1'b1, 8'h0D);
        @(negedge clk);
        chk("b2b_setup", pack_a(), {13'd0, 4'h0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0});
        start_a = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done_a) seen = 1'b1;
        end
        chk("b2b_done_seen", {31'd0, seen}, 32'd1);
        chk("b2b_sum", {24'd0, sum_a}, 32'h0D);

        // Asynchronous reset in the middle of a strobe (cycle 14).
        @(negedge clk);
        frame_a = 32'h0130_1062;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (13) @(negedge clk);
        chk("pre_rst_read", {31'd0, read_a}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_async", {27'd0, read_a, busy_a, idx_a}, 32'd0);
        chk("rst_async_sum", {24'd0, sum_a}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        active = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (read_a || busy_a || done_a) active = 1'b1;
        end
        chk("rst_no_activity", {31'd0, active}, 32'd0);

        // 20 all-F nibbles: 300 wraps to 8'h2C.
        @(negedge clk);
        frame_b = '1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        c = 1;
        seen = 1'b0;
        while (c <= 200 && !seen) begin
            if (done_b) seen = 1'b1;
            else begin
                @(negedge clk);
                c++;
            end
        end
        chk("n20_done_seen", {31'd0, seen}, 32'd1);
        chk("n20_done_cycle", c, 32'd81);
        chk("n20_sum", {24'd0, sum_b}, 32'h2C);
        chk("n20_index", {27'd0, idx_b}, 32'd20);

        // SETUP=2, STROBE=1: P=3.
        @(negedge clk);
        frame_c = 32'h0130_1062;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        c = 1;
        seen = 1'b0;
        reads = 0; run = 0; max_run = 0;
        while (c <= 200 && !seen) begin
            if (read_c) begin
                reads++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (done_c) seen = 1'b1;
            else begin
                @(negedge clk);
                c++;
            end
        end
        chk("p3_done_seen", {31'd0, seen}, 32'd1);
        chk("p3_done_cycle", c, 32'd25);
        chk("p3_read_cycles", reads, 32'd8);
        chk("p3_read_run", max_run, 32'd1);
        chk("p3_sum", {24'd0, sum_c}, 32'h0D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
